// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key controller: Set-2 scan codes, ASCII codes
// and the prefix FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  localparam logic [7:0] ASC_0       = 8'h30;
  localparam logic [7:0] ASC_LOWER_A = 8'h61;
  localparam logic [7:0] ASC_UPPER_A = 8'h41;
  localparam logic [7:0] ASC_CR      = 8'h0D;
  localparam logic [7:0] ASC_BS      = 8'h08;
  localparam logic [7:0] ASC_SP      = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

endpackage

// File: rtl/ps2_char_fifo.sv
// Synchronous character FIFO with full/empty flags; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module ps2_char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  // Head reads as zero while empty so the output has a defined reset value.
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 Set-2 key sequencer: prefix tracking, shift state, hex-entry key
// translation to ASCII and a buffered valid/ready character stream.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       new_code,
  output logic       ev_valid,
  output logic [7:0] ev_char,
  input  logic       ev_ready,
  output logic       shift_active,
  output logic       ovf
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  ps2_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic new_code_q, new_code_d;
  logic lshift_q, lshift_d;
  logic rshift_q, rshift_d;
  logic ovf_q, ovf_d;
  logic byte_stb, is_make, is_brk, is_ext;
  logic [8:0] xlat;
  logic push, pop, fifo_full, fifo_empty;

  // Returns {hit, ascii}; hit is low for keys outside the hex-entry subset.
  function automatic logic [8:0] translate(input logic [7:0] code,
                                           input logic ext,
                                           input logic shift);
    logic [7:0] alpha;
    alpha     = shift ? ASC_UPPER_A : ASC_LOWER_A;
    translate = '0;
    if (ext) begin
      if (code == SC_ENTER) translate = {1'b1, ASC_CR};
    end else begin
      case (code)
        SC_0:     translate = {1'b1, ASC_0};
        SC_1:     translate = {1'b1, ASC_0 + 8'd1};
        SC_2:     translate = {1'b1, ASC_0 + 8'd2};
        SC_3:     translate = {1'b1, ASC_0 + 8'd3};
        SC_4:     translate = {1'b1, ASC_0 + 8'd4};
        SC_5:     translate = {1'b1, ASC_0 + 8'd5};
        SC_6:     translate = {1'b1, ASC_0 + 8'd6};
        SC_7:     translate = {1'b1, ASC_0 + 8'd7};
        SC_8:     translate = {1'b1, ASC_0 + 8'd8};
        SC_9:     translate = {1'b1, ASC_0 + 8'd9};
        SC_A:     translate = {1'b1, alpha};
        SC_B:     translate = {1'b1, alpha + 8'd1};
        SC_C:     translate = {1'b1, alpha + 8'd2};
        SC_D:     translate = {1'b1, alpha + 8'd3};
        SC_E:     translate = {1'b1, alpha + 8'd4};
        SC_F:     translate = {1'b1, alpha + 8'd5};
        SC_ENTER: translate = {1'b1, ASC_CR};
        SC_BKSP:  translate = {1'b1, ASC_BS};
        SC_SPACE: translate = {1'b1, ASC_SP};
        default:  translate = '0;
      endcase
    end
  endfunction

  always_comb begin
    byte_stb   = new_code & ~new_code_q;
    new_code_d = new_code;
    state_d    = state_q;
    cnt_d      = cnt_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    is_make    = 1'b0;
    is_brk     = 1'b0;
    is_ext     = 1'b0;

    if (byte_stb) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_EXT)      state_d = ST_EXT;
          else if (scan_code == SC_BRK) state_d = ST_BRK;
          else                          is_make = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_brk  = 1'b1;
          is_ext  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      // A stalled prefix is dropped so the next byte is decoded from scratch.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!is_ext) begin
      if (scan_code == SC_LSHIFT) begin
        if (is_make) lshift_d = 1'b1;
        if (is_brk)  lshift_d = 1'b0;
      end
      if (scan_code == SC_RSHIFT) begin
        if (is_make) rshift_d = 1'b1;
        if (is_brk)  rshift_d = 1'b0;
      end
    end

    xlat  = translate(scan_code, is_ext, lshift_q | rshift_q);
    push  = is_make & xlat[8];
    pop   = ev_valid & ev_ready;
    ovf_d = ovf_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      new_code_q <= 1'b0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      new_code_q <= new_code_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (xlat[7:0]),
    .pop   (pop),
    .dout  (ev_char),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid     = ~fifo_empty;
  assign shift_active = lshift_q | rshift_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with a queue-based behavioural model checked
// every cycle, plus literal expectations on the delivered character stream.
module tb_ps2_key_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] LET [6]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       new_code = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_char;
  logic       shift_active;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq [$];
  logic [7:0] mlog [$];
  logic [7:0] glog [$];
  logic [7:0] exp_q [$];
  logic m_ovf = 1'b0, m_lsh = 1'b0, m_rsh = 1'b0;
  logic m_ext = 1'b0, m_brk = 1'b0, m_prev = 1'b0;
  int   cyc = 0, last_cyc = 0;

  ps2_key_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_code    (scan_code),
    .new_code     (new_code),
    .ev_valid     (ev_valid),
    .ev_char      (ev_char),
    .ev_ready     (ev_ready),
    .shift_active (shift_active),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // {mapped, ascii} from the key tables.
  function automatic logic [8:0] ascii_of(logic [7:0] c, logic ext, logic sh);
    if (ext) return (c == 8'h5A) ? {1'b1, 8'h0D} : 9'h000;
    for (int i = 0; i < 10; i++)
      if (c == DIG[i]) return {1'b1, 8'h30 + 8'(i)};
    for (int i = 0; i < 6; i++)
      if (c == LET[i]) return {1'b1, (sh ? 8'h41 : 8'h61) + 8'(i)};
    if (c == 8'h5A) return {1'b1, 8'h0D};
    if (c == 8'h66) return {1'b1, 8'h08};
    if (c == 8'h29) return {1'b1, 8'h20};
    return 9'h000;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_ovf = 0; m_lsh = 0; m_rsh = 0; m_ext = 0; m_brk = 0; m_prev = 0;
    cyc = 0; last_cyc = 0;
  end

  always @(posedge clk) begin
    logic stb, pop, mk, bk, ek;
    logic [8:0] t;
    if (rst_n) begin
      cyc++;
      stb = new_code && !m_prev;
      m_prev = new_code;
      pop = (mq.size() > 0) && ev_ready;
      mk = 0; bk = 0; ek = 0;
      if (stb) begin
        if ((m_ext || m_brk) && (cyc - last_cyc > TMO)) begin
          m_ext = 0; m_brk = 0;
        end
        last_cyc = cyc;
        if (m_brk) begin
          bk = 1; ek = m_ext; m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
          if (scan_code == 8'hF0) m_brk = 1;
          else begin mk = 1; ek = 1; m_ext = 0; end
        end else if (scan_code == 8'hE0) m_ext = 1;
        else if (scan_code == 8'hF0) m_brk = 1;
        else mk = 1;
      end
      if (mk) begin
        t = ascii_of(scan_code, ek, m_lsh | m_rsh);
        if (t[8]) begin
          if (mq.size() < DEPTH || pop) mq.push_back(t[7:0]);
          else m_ovf = 1;
        end
        if (!ek && scan_code == 8'h12) m_lsh = 1;
        if (!ek && scan_code == 8'h59) m_rsh = 1;
      end
      if (bk && !ek && scan_code == 8'h12) m_lsh = 0;
      if (bk && !ek && scan_code == 8'h59) m_rsh = 0;
      if (pop) mlog.push_back(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
      chk("ev_char", 32'(ev_char), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      chk("shift_active", 32'(shift_active), 32'(m_lsh | m_rsh));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (ev_valid && ev_ready) glog.push_back(ev_char);
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    scan_code = b;
    new_code  = 1'b1;
    @(posedge clk); #1;
    new_code  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; new_code = 1'b0; ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    glog.delete(); mlog.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string name);
    ev_ready = 1'b1;
    idle(DEPTH + 3);
    chk({name, "_count"}, 32'(glog.size()), 32'(exp_q.size()));
    chk({name, "_model_count"}, 32'(mlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < glog.size()) chk({name, "_char"}, 32'(glog[i]), 32'(exp_q[i]));
      if (i < mlog.size()) chk({name, "_model_char"}, 32'(mlog[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ev_valid", 32'(ev_valid), 32'h0);
    chk("rst_ev_char", 32'(ev_char), 32'h0);
    chk("rst_shift", 32'(shift_active), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;

    // Make and break of '1'
    ev_ready = 1'b1;
    send(8'h16);
    chk("t1_valid_next_cycle", 32'(ev_valid), 32'h1);
    chk("t1_char_next_cycle", 32'(ev_char), 32'h31);
    send(8'hF0); send(8'h16);
    exp_q = '{8'h31};
    check_log("t1");

    // Shift handling, extended shift ignored, control keys
    do_reset();
    ev_ready = 1'b1;
    send(8'h12);
    chk("t2_shift_on", 32'(shift_active), 32'h1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_shift_off", 32'(shift_active), 32'h0);
    send(8'h1C);
    send(8'h59); send(8'h2B); send(8'hF0); send(8'h59);
    send(8'hE0); send(8'h12); send(8'h1C);
    send(8'h12); send(8'h66); send(8'h29); send(8'h45); send(8'hF0); send(8'h12);
    exp_q = '{8'h41, 8'h61, 8'h46, 8'h61, 8'h08, 8'h20, 8'h30};
    check_log("t2");

    // Keypad enter make and break, then plain key decodes from idle
    do_reset();
    ev_ready = 1'b1;
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A); send(8'h16);
    exp_q = '{8'h0D, 8'h31};
    check_log("t3");

    // Level held high yields one byte
    do_reset();
    ev_ready = 1'b1;
    @(posedge clk); #1;
    scan_code = 8'h45; new_code = 1'b1;
    idle(50);
    new_code = 1'b0;
    exp_q = '{8'h30};
    check_log("t4");

    // Overflow and push-while-full-with-pop
    do_reset();
    ev_ready = 1'b0;
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    chk("t5_ovf", 32'(ovf), 32'h1);
    chk("t5_head", 32'(ev_char), 32'h31);
    @(posedge clk); #1;
    scan_code = 8'h36; new_code = 1'b1; ev_ready = 1'b1;
    @(posedge clk); #1;
    new_code = 1'b0; ev_ready = 1'b0;
    chk("t5_head_after_pop", 32'(ev_char), 32'h32);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36};
    check_log("t5");
    chk("t5_ovf_sticky", 32'(ovf), 32'h1);

    // Prefix timeout boundary
    do_reset();
    ev_ready = 1'b1;
    send(8'hE0); idle(TMO - 2); send(8'h16);
    send(8'hE0); idle(TMO - 1); send(8'h16);
    send(8'hE0); idle(TMO + 5); send(8'h5A);
    exp_q = '{8'h31, 8'h0D};
    check_log("t6");

    // Asynchronous reset mid-prefix with state held
    do_reset();
    ev_ready = 1'b0;
    send(8'h12); send(8'h16); send(8'hF0);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_ev_valid", 32'(ev_valid), 32'h0);
    chk("t7_rst_ev_char", 32'(ev_char), 32'h0);
    chk("t7_rst_shift", 32'(shift_active), 32'h0);
    chk("t7_rst_ovf", 32'(ovf), 32'h0);
    idle(2);
    glog.delete(); mlog.delete();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    send(8'h16);
    exp_q = '{8'h31};
    check_log("t7");

    // new_code already high when reset releases
    @(posedge clk); #1;
    rst_n = 1'b0; ev_ready = 1'b0;
    scan_code = 8'h45; new_code = 1'b1;
    idle(2);
    glog.delete(); mlog.delete();
    rst_n = 1'b1;
    idle(3);
    new_code = 1'b0;
    exp_q = '{8'h30};
    check_log("t8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencing controller behind the PS/2 receiver.
- Consumes the receiver's `scan_code`/`new_code` stream and tracks the Set-2 prefix sequence (E0 extended, F0 break).
- Maintains shift state and translates make codes of the hex-entry key subset into ASCII characters.
- Buffers characters in a small FIFO with a valid/ready handshake toward the RSA operand-entry logic.

## Interface
- `FIFO_DEPTH`, 4: character FIFO entries, power of two, ≥2.
- `TIMEOUT_CYC`, 100000: idle cycles after a prefix byte before the prefix state is abandoned.
- `clk` in 1: system clock, shared with the PS/2 receiver.
- `rst_n` in 1: reset; asynchronous and active-low.
- `scan_code` in 8: byte from the receiver; valid while `new_code` is high.
- `new_code` in 1: level from the receiver, may stay high for many cycles; its rising edge marks one new byte.
- `ev_valid` out 1: FIFO non-empty; `ev_char` holds the head entry.
- `ev_char` out 8: ASCII of the head entry.
- `ev_ready` in 1: consumer accepts the head when `ev_valid` and `ev_ready` are both high.
- `shift_active` out 1: left or right shift currently held.
- `ovf` out 1: sticky, set when a character is dropped because the FIFO is full.

## Operation
**Byte capture**
- Register `new_code_q`.
- `byte_stb = new_code & ~new_code_q`. Only strobed bytes are acted on.

**Prefix FSM**
- States: IDLE, EXT, BRK, EXT_BRK.
- IDLE: E0→EXT; F0→BRK; any other byte is a make, handled as below, FSM stays in IDLE.
- EXT: F0→EXT_BRK; any other byte is an extended make, then→IDLE.
- BRK: byte is a break, then→IDLE.
- EXT_BRK: byte is an extended break, then→IDLE.

**Shift tracking**
- Make 12 or 59 (non-extended) sets the corresponding held bit.
- Break of the same code clears it.
- `shift_active` = OR of the two held bits.

**Translation (non-extended makes only)**
- Digits: 45→'0', 16→'1', 1E→'2', 26→'3', 25→'4', 2E→'5', 36→'6', 3D→'7', 3E→'8', 46→'9'.
- Letters: 1C→a, 32→b, 21→c, 23→d, 24→e, 2B→f. Uppercase (A–F) when `shift_active` is high.
- Control keys: 5A→0x0D, 66→0x08, 29→0x20.
- Extended make 5A (keypad enter) →0x0D.
- Shift does not affect digits or control codes.
- All other makes, every break, and every unlisted extended make are ignored.
- Typematic repeats are emitted as new characters.

**FIFO**
- A mapped make pushes one character.
- Push while full with no pop in the same cycle: character dropped, `ovf`←1.
- Push while full with a pop in the same cycle: push accepted.
- Pop occurs on `ev_valid & ev_ready`.
- Pointers wrap modulo `FIFO_DEPTH`.

**Timeout**
- Counter clears on every `byte_stb` and whenever the FSM is in IDLE.
- In EXT, BRK or EXT_BRK, when the count reaches `TIMEOUT_CYC-1` the FSM returns to IDLE.
- Shift bits and FIFO are unaffected by a timeout.

## Timing
- Reset values: FSM IDLE, FIFO empty, `ev_valid`=0, `ev_char`=0x00, `shift_active`=0, `ovf`=0, `new_code_q`=0.
- If `new_code` is high when reset releases, the first cycle counts as a rising edge.
- Latency: `byte_stb` in cycle N → FIFO write at the end of N → `ev_valid`=1 in N+1 if the FIFO was empty.
- `shift_active` updates in N+1.
- `ev_char` is stable while `ev_valid` is high and not yet popped.
- Throughput: one pop per cycle.
- Reset asserted mid-prefix or mid-drain returns every output to its reset value immediately (asynchronously).

## Structure
- Shared package `ps2_pkg` holds:
  - scan-code constants (E0, F0, shift codes, key codes);
  - ASCII constants;
  - FSM state encoding.
- One sub-module, `ps2_char_fifo`: synchronous FIFO, parameterised depth, 8-bit data, full/empty flags and simultaneous push/pop support.
- Translation is a combinational function inside `ps2_key_ctrl`.

## Test plan
- Strobes 16, F0 16 with `ev_ready`=1 → exactly one event 0x31 ('1'), `ev_valid` rising one cycle after the first strobe.
- Strobes 12, 1C, F0 1C, F0 12, 1C → events 0x41 then 0x61; `shift_active` high only between the 12 make and its break.
- Strobes E0 5A, then E0 F0 5A → one event 0x0D; FSM returns to IDLE; no event for the break.
- Hold `new_code` high for 50 cycles with 45 → exactly one event 0x30.
- `ev_ready`=0, FIFO_DEPTH=4, five mapped makes → four entries retained in order, fifth dropped, `ovf`=1. Pop one in the same cycle as a sixth push → push accepted.
- Strobe E0, wait `TIMEOUT_CYC` cycles, strobe 5A → ASCII 0x0D produced via the non-extended path.
- Strobe F0, assert `rst_n`=0 mid-wait, release, strobe 16 → event '1' emitted, not treated as a break.
